// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional-encoder framing logic:
// controller state encoding and termination-mode constants.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_DATA,
    ST_TAIL,
    ST_DONE
  } frame_state_e;

  localparam logic MODE_TERM = 1'b0;
  localparam logic MODE_TB   = 1'b1;

endpackage

// File: rtl/conv_frame_ctrl.sv
// Frame controller feeding a rate-1/2 convolutional encoder: seeds it, passes info bits,
// appends a zero tail or relies on tail-biting. Optional stats counters: CONV_FRAME_STATS_EN.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int K     = 4,
  parameter int M     = K - 1,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [M-1:0]     tb_seed,
  input  logic             abort,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  input  logic             sink_ready,
  output logic             enc_seed_load,
  output logic [M-1:0]     enc_seed_value,
  output logic             enc_in_valid,
  output logic             enc_in_bit,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef CONV_FRAME_STATS_EN
  ,
  output logic [15:0]      frames_ok,
  output logic [15:0]      frames_aborted
`endif
);

  localparam int TW = $clog2(M + 1);

  frame_state_e     state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [M-1:0]     seed_q, seed_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tail_q, tail_d;
  logic             first_q, first_d;
  logic             sof_q, eof_q, err_q, err_d;
  logic             last_in;
  logic             abort_fx;

  assign abort_fx = abort & (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign out_sof  = sof_q;
  assign out_eof  = eof_q;
  assign err      = err_q;

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    len_d          = len_q;
    seed_d         = seed_q;
    cnt_d          = cnt_q;
    tail_d         = tail_q;
    first_d        = first_q;
    err_d          = 1'b0;
    last_in        = 1'b0;
    s_ready        = 1'b0;
    enc_seed_load  = 1'b0;
    enc_seed_value = '0;
    enc_in_valid   = 1'b0;
    enc_in_bit     = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            err_d = 1'b1;
          end else begin
            mode_d  = mode;
            len_d   = frame_len;
            seed_d  = tb_seed;
            cnt_d   = '0;
            tail_d  = '0;
            first_d = 1'b1;
            state_d = ST_SEED;
          end
        end
      end
      ST_SEED: begin
        enc_seed_load  = 1'b1;
        enc_seed_value = (mode_q == MODE_TB) ? seed_q : '0;
        state_d        = ST_DATA;
      end
      ST_DATA: begin
        s_ready      = sink_ready;
        enc_in_valid = s_valid & sink_ready;
        enc_in_bit   = s_bit;
        if (enc_in_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            last_in = (mode_q == MODE_TB);
            state_d = (mode_q == MODE_TB) ? ST_DONE : ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        enc_in_valid = sink_ready;
        if (sink_ready) begin
          tail_d = tail_q + TW'(1);
          if (tail_q == TW'(M - 1)) begin
            last_in = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything: nothing is accepted or issued in the abort cycle.
    if (abort_fx) begin
      state_d      = ST_IDLE;
      s_ready      = 1'b0;
      enc_in_valid = 1'b0;
      done         = 1'b0;
      last_in      = 1'b0;
    end

    if (enc_in_valid) first_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_TERM;
      len_q   <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      first_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      first_q <= first_d;
      sof_q   <= enc_in_valid & first_q;
      eof_q   <= enc_in_valid & last_in;
      err_q   <= err_d;
    end
  end

`ifdef CONV_FRAME_STATS_EN
  logic [15:0] ok_q, ab_q;

  // Saturating frame statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_q <= '0;
      ab_q <= '0;
    end else begin
      if (done && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
      if (abort_fx && ab_q != 16'hFFFF) ab_q <= ab_q + 16'd1;
    end
  end

  assign frames_ok      = ok_q;
  assign frames_aborted = ab_q;
`endif

endmodule
